// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin encodings, amount width and dispenser states.
// Coin codes equal their face values, so a code converts to an amount directly.
package vend_pkg;

    localparam int AMT_W = 4;

    localparam logic [2:0] COIN_1 = 3'd1;
    localparam logic [2:0] COIN_2 = 3'd2;
    localparam logic [2:0] COIN_5 = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EJECT  = 2'd2,
        DONE   = 2'd3
    } disp_state_t;

    function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] coin);
        return {1'b0, coin};
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request, coin-eject and status signals between the vending controller and the change dispenser.
interface change_dispenser_if;
    import vend_pkg::*;

    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             coin_valid;
    logic [2:0]       coin_type;
    logic             coin_ack;
    logic             refill;
    logic             done;
    logic [AMT_W-1:0] shortfall;
    logic [2:0]       empty;

    modport master (
        output req_valid, req_amount, coin_ack, refill,
        input  req_ready, coin_valid, coin_type, done, shortfall, empty
    );

    modport slave (
        input  req_valid, req_amount, coin_ack, refill,
        output req_ready, coin_valid, coin_type, done, shortfall, empty
    );

endinterface

// File: rtl/coin_bank.sv
// Inventory counter for one coin denomination; a load (refill) wins over a dispense.
module coin_bank #(
    parameter int CNT_W      = 4,
    parameter int INIT_COUNT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= CNT_W'(INIT_COUNT);
        end else if (load) begin
            count <= CNT_W'(INIT_COUNT);
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign empty = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays a requested balance out as coins, largest first, one coin per ejector handshake,
// and reports whatever could not be paid from the remaining inventory.
//
//   state  | meaning
//   IDLE   | waiting for a request; refill allowed
//   SELECT | pick the largest affordable coin in stock, or finish
//   EJECT  | coin_valid held until the ejector acks
//   DONE   | one-cycle done pulse with shortfall
module change_dispenser
    import vend_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int INIT_COUNT = 8
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus
);

    disp_state_t      state;
    logic [AMT_W-1:0] remaining;
    logic [2:0]       pick;
    logic             req_ready;
    logic             coin_valid;
    logic [2:0]       coin_type;
    logic             done;
    logic [AMT_W-1:0] shortfall;
    logic             load;
    logic             ack_fire;
    logic             dec1, dec2, dec5;
    logic             empty1, empty2, empty5;
    logic [CNT_W-1:0] cnt1, cnt2, cnt5;

    assign load     = (state == IDLE) && bus.refill;
    assign ack_fire = (state == EJECT) && coin_valid && bus.coin_ack;
    assign dec1     = ack_fire && (coin_type == COIN_1);
    assign dec2     = ack_fire && (coin_type == COIN_2);
    assign dec5     = ack_fire && (coin_type == COIN_5);

    coin_bank #(.CNT_W(CNT_W), .INIT_COUNT(INIT_COUNT)) u_bank1 (
        .clk(clk), .rst(rst), .load(load), .dec(dec1), .count(cnt1), .empty(empty1)
    );
    coin_bank #(.CNT_W(CNT_W), .INIT_COUNT(INIT_COUNT)) u_bank2 (
        .clk(clk), .rst(rst), .load(load), .dec(dec2), .count(cnt2), .empty(empty2)
    );
    coin_bank #(.CNT_W(CNT_W), .INIT_COUNT(INIT_COUNT)) u_bank5 (
        .clk(clk), .rst(rst), .load(load), .dec(dec5), .count(cnt5), .empty(empty5)
    );

    // Greedy choice with fallback; a coin is only picked when it fits, so remaining never wraps.
    always_comb begin
        pick = 3'd0;
        if ((remaining >= coin_value(COIN_5)) && (cnt5 != '0)) begin
            pick = COIN_5;
        end else if ((remaining >= coin_value(COIN_2)) && (cnt2 != '0)) begin
            pick = COIN_2;
        end else if ((remaining >= coin_value(COIN_1)) && (cnt1 != '0)) begin
            pick = COIN_1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            remaining  <= '0;
            req_ready  <= 1'b1;
            coin_valid <= 1'b0;
            coin_type  <= 3'd0;
            done       <= 1'b0;
            shortfall  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        remaining <= bus.req_amount;
                        req_ready <= 1'b0;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (pick != 3'd0) begin
                        coin_type  <= pick;
                        coin_valid <= 1'b1;
                        state      <= EJECT;
                    end else begin
                        done      <= 1'b1;
                        shortfall <= remaining;
                        state     <= DONE;
                    end
                end
                EJECT: begin
                    if (ack_fire) begin
                        remaining  <= remaining - coin_value(coin_type);
                        coin_valid <= 1'b0;
                        coin_type  <= 3'd0;
                        state      <= SELECT;
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.coin_valid = coin_valid;
    assign bus.coin_type  = coin_type;
    assign bus.done       = done;
    assign bus.shortfall  = shortfall;
    assign bus.empty      = {empty5, empty2, empty1};

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: one instance with the default inventory of 8,
// one with an inventory of 1 per denomination for shortfall and refill scenarios.
module tb_change_dispenser;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    change_dispenser_if ia ();
    change_dispenser_if ib ();

    change_dispenser #(.CNT_W(4), .INIT_COUNT(8)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    change_dispenser #(.CNT_W(4), .INIT_COUNT(1)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    always #5 clk = ~clk;

    // Issue a request with the ack held high; record coins (3 bits each, oldest highest).
    task automatic pay_a(input logic [3:0] amt, output logic [23:0] seq, output int n,
                         output int dones, output logic [3:0] sf, output bit tmo);
        seq = '0; n = 0; dones = 0; sf = '0; tmo = 1'b1;
        ia.req_amount = amt; ia.req_valid = 1'b1; ia.coin_ack = 1'b1;
        @(posedge clk); #1;
        ia.req_valid = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk); #1;
            if (ia.coin_valid) begin seq = {seq[20:0], ia.coin_type}; n++; end
            if (ia.done) begin dones++; sf = ia.shortfall; end
            if (dones > 0 && ia.req_ready) begin tmo = 1'b0; break; end
        end
        ia.coin_ack = 1'b0;
    endtask

    task automatic pay_b(input logic [3:0] amt, output logic [23:0] seq, output int n,
                         output int dones, output logic [3:0] sf, output bit tmo);
        seq = '0; n = 0; dones = 0; sf = '0; tmo = 1'b1;
        ib.req_amount = amt; ib.req_valid = 1'b1; ib.coin_ack = 1'b1;
        @(posedge clk); #1;
        ib.req_valid = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk); #1;
            if (ib.coin_valid) begin seq = {seq[20:0], ib.coin_type}; n++; end
            if (ib.done) begin dones++; sf = ib.shortfall; end
            if (dones > 0 && ib.req_ready) begin tmo = 1'b0; break; end
        end
        ib.coin_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #23 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ia.req_ready !== 1'b1 || ia.coin_valid !== 1'b0 || ia.coin_type !== 3'd0 ||
            ia.done !== 1'b0 || ia.shortfall !== 4'd0 || ia.empty !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b type=%0d done=%b sf=%0d empty=%b, want 1 0 0 0 0 000",
                     ia.req_ready, ia.coin_valid, ia.coin_type, ia.done, ia.shortfall, ia.empty);
        end
        checks++;
        if (ib.req_ready !== 1'b1 || ib.empty !== 3'b000) begin
            errors++;
            $display("FAIL reset_b: ready=%b empty=%b, want 1 000", ib.req_ready, ib.empty);
        end
    endtask

    task automatic test_basic();
        logic [23:0] seq; int n; int dones; logic [3:0] sf; bit tmo;
        pay_a(4'd8, seq, n, dones, sf, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL basic_timeout: no done within budget"); end
        checks++;
        if (seq !== 24'h000151 || n !== 3) begin
            errors++; $display("FAIL basic_coins: seq=%h n=%0d, want 000151 n=3", seq, n);
        end
        checks++;
        if (dones !== 1 || sf !== 4'd0) begin
            errors++; $display("FAIL basic_done: dones=%0d sf=%0d, want 1 0", dones, sf);
        end
        checks++;
        if (dut_a.cnt5 !== 4'd7 || dut_a.cnt2 !== 4'd7 || dut_a.cnt1 !== 4'd7) begin
            errors++;
            $display("FAIL basic_counts: %0d/%0d/%0d, want 7/7/7", dut_a.cnt5, dut_a.cnt2, dut_a.cnt1);
        end
    endtask

    task automatic test_zero();
        ia.req_amount = 4'd0; ia.req_valid = 1'b1;
        @(posedge clk); #1;
        ia.req_valid = 1'b0;
        checks++;
        if (ia.done !== 1'b0 || ia.coin_valid !== 1'b0 || ia.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_select: done=%b valid=%b ready=%b, want 0 0 0", ia.done, ia.coin_valid, ia.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (ia.done !== 1'b1 || ia.shortfall !== 4'd0 || ia.coin_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b sf=%0d valid=%b, want 1 0 0", ia.done, ia.shortfall, ia.coin_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (ia.done !== 1'b0 || ia.req_ready !== 1'b1) begin
            errors++; $display("FAIL zero_idle: done=%b ready=%b, want 0 1", ia.done, ia.req_ready);
        end
    endtask

    task automatic test_init1();
        logic [23:0] seq; int n; int dones; logic [3:0] sf; bit tmo;
        pay_b(4'd15, seq, n, dones, sf, tmo);
        checks++;
        if (tmo || seq !== 24'h000151 || n !== 3 || dones !== 1) begin
            errors++;
            $display("FAIL init1_coins: tmo=%b seq=%h n=%0d dones=%0d, want 0 000151 3 1", tmo, seq, n, dones);
        end
        checks++;
        if (sf !== 4'd7 || ib.empty !== 3'b111) begin
            errors++; $display("FAIL init1_short: sf=%0d empty=%b, want 7 111", sf, ib.empty);
        end
        ib.refill = 1'b1;
        @(posedge clk); #1;
        ib.refill = 1'b0;
        checks++;
        if (ib.empty !== 3'b000) begin
            errors++; $display("FAIL refill_empty: empty=%b, want 000", ib.empty);
        end
        pay_b(4'd3, seq, n, dones, sf, tmo);
        checks++;
        if (tmo || seq !== 24'h000011 || n !== 2 || sf !== 4'd0) begin
            errors++;
            $display("FAIL refill_pay3: tmo=%b seq=%h n=%0d sf=%0d, want 0 000011 2 0", tmo, seq, n, sf);
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        ia.req_amount = 4'd5; ia.req_valid = 1'b1; ia.coin_ack = 1'b0;
        @(posedge clk); #1;
        ia.req_amount = 4'd9; ia.refill = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ia.coin_valid !== 1'b1 || ia.coin_type !== 3'd5) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_hold: %0d of 4 cycles unstable, want 0", bad);
        end
        ia.coin_ack = 1'b1;
        @(posedge clk); #1;
        ia.coin_ack = 1'b0; ia.req_valid = 1'b0; ia.refill = 1'b0;
        checks++;
        if (ia.coin_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release: valid=%b, want 0", ia.coin_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (ia.done !== 1'b1 || ia.shortfall !== 4'd0) begin
            errors++; $display("FAIL stall_done: done=%b sf=%0d, want 1 0", ia.done, ia.shortfall);
        end
        checks++;
        if (dut_a.cnt5 !== 4'd6 || dut_a.cnt2 !== 4'd7 || dut_a.cnt1 !== 4'd7) begin
            errors++;
            $display("FAIL stall_counts: %0d/%0d/%0d, want 6/7/7", dut_a.cnt5, dut_a.cnt2, dut_a.cnt1);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (ia.req_ready !== 1'b1 || ia.coin_valid !== 1'b0) begin
            errors++; $display("FAIL stall_ignored_req: ready=%b valid=%b, want 1 0", ia.req_ready, ia.coin_valid);
        end
    endtask

    task automatic test_greedy();
        logic [23:0] seq; int n; int dones; logic [3:0] sf; bit tmo;
        for (int i = 0; i < 7; i++) pay_a(4'd1, seq, n, dones, sf, tmo);
        checks++;
        if (ia.empty !== 3'b001) begin
            errors++; $display("FAIL drain_ones: empty=%b, want 001", ia.empty);
        end
        pay_a(4'd6, seq, n, dones, sf, tmo);
        checks++;
        if (tmo || seq !== 24'h000005 || n !== 1 || sf !== 4'd1) begin
            errors++;
            $display("FAIL greedy_6: tmo=%b seq=%h n=%0d sf=%0d, want 0 000005 1 1", tmo, seq, n, sf);
        end
        checks++;
        if (dut_a.cnt5 !== 4'd5 || dut_a.cnt2 !== 4'd7) begin
            errors++; $display("FAIL greedy_counts: cnt5=%0d cnt2=%0d, want 5 7", dut_a.cnt5, dut_a.cnt2);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        ia.req_amount = 4'd5; ia.req_valid = 1'b1; ia.coin_ack = 1'b0;
        @(posedge clk); #1;
        ia.req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ia.coin_valid !== 1'b1) begin
            errors++; $display("FAIL mid_eject: valid=%b, want 1", ia.coin_valid);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ia.coin_valid !== 1'b0 || ia.coin_type !== 3'd0 || ia.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_async: valid=%b type=%0d ready=%b, want 0 0 1", ia.coin_valid, ia.coin_type, ia.req_ready);
        end
        repeat (2) begin @(posedge clk); #1; if (ia.done) dones++; end
        rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; if (ia.done) dones++; end
        checks++;
        if (dones != 0 || ia.req_ready !== 1'b1 || ia.coin_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: dones=%0d ready=%b valid=%b, want 0 1 0", dones, ia.req_ready, ia.coin_valid);
        end
        checks++;
        if (dut_a.cnt5 !== 4'd8 || dut_a.cnt2 !== 4'd8 || dut_a.cnt1 !== 4'd8 || ia.empty !== 3'b000) begin
            errors++;
            $display("FAIL mid_counts: %0d/%0d/%0d empty=%b, want 8/8/8 000",
                     dut_a.cnt5, dut_a.cnt2, dut_a.cnt1, ia.empty);
        end
    endtask

    initial begin
        ia.req_valid = 1'b0; ia.req_amount = 4'd0; ia.coin_ack = 1'b0; ia.refill = 1'b0;
        ib.req_valid = 1'b0; ib.req_amount = 4'd0; ib.coin_ack = 1'b0; ib.refill = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_init1();
        test_stall();
        test_greedy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
